// File: rtl/ahb2apb_bridge_nslv.sv
// ahb2apb_bridge_nslv: AHB-Lite slave to APB master bridge driving NUM_SLV one-hot selected completers
// Ports: hclk, hreset (async, active-high); AHB slave side hsel, haddr, htrans, hwrite,
// hready, hwdata in and hreadyout, hresp, hrdata out; APB master side paddr, psel,
// penable, pwrite, pwdata out and prdata (slave i at [i*DATA_W +: DATA_W]), pready,
// pslverr in; to_event pulses for one cycle (in ERR1) after an APB access timeout.
module ahb2apb_bridge_nslv #(
   parameter int HADDR_W = 32,
   parameter int PADDR_W = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_SLV = 12,
   parameter int SEL_LSB = 12,
   parameter int SEL_W   = 4,
   parameter int TIMEOUT = 256
) (
   input  logic                      hclk,
   input  logic                      hreset,
   input  logic                      hsel,
   input  logic [HADDR_W-1:0]        haddr,
   input  logic [1:0]                htrans,
   input  logic                      hwrite,
   input  logic                      hready,
   input  logic [DATA_W-1:0]         hwdata,
   output logic                      hreadyout,
   output logic                      hresp,
   output logic [DATA_W-1:0]         hrdata,
   output logic [PADDR_W-1:0]        paddr,
   output logic [NUM_SLV-1:0]        psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [DATA_W-1:0]         pwdata,
   input  logic [NUM_SLV*DATA_W-1:0] prdata,
   input  logic [NUM_SLV-1:0]        pready,
   input  logic [NUM_SLV-1:0]        pslverr,
   output logic                      to_event
);
   localparam int CNT_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [2:0] IDLE = 3'd0, WDATA = 3'd1, SETUP = 3'd2, ACCESS = 3'd3, ERR1 = 3'd4, ERR2 = 3'd5;
   logic [2:0]         state_q, state_d;
   logic [PADDR_W-1:0] addr_q, addr_d;
   logic               write_q, write_d;
   logic [SEL_W-1:0]   idx_q, idx_d, idx_in;
   logic [DATA_W-1:0]  pwdata_q, pwdata_d, hrdata_q, hrdata_d, rd_slice;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               to_q, to_d;
   logic [NUM_SLV-1:0] sel_oh;
   logic               accept, rdy, err, tmo;
   logic               unused;
   assign unused = &{1'b0, htrans[0]};
   assign idx_in = haddr[SEL_LSB +: SEL_W];
   assign accept = (state_q == IDLE || state_q == ERR2) && hsel && hready && htrans[1];
   // out-of-range indices shift the one bit out, so decode errors select nothing
   assign sel_oh = NUM_SLV'(1) << idx_q;
   assign rdy    = |(pready & sel_oh);
   assign err    = |(pslverr & sel_oh);
   // fires on the TIMEOUT-th consecutive not-ready ACCESS cycle; pready wins a tie
   assign tmo    = TIMEOUT != 0 && !rdy && cnt_q == CNT_W'(TIMEOUT - 1);
   always_comb begin
      rd_slice = '0;
      for (int i = 0; i < NUM_SLV; i++) rd_slice |= sel_oh[i] ? prdata[i*DATA_W +: DATA_W] : '0;
   end
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      write_d  = write_q;
      idx_d    = idx_q;
      pwdata_d = pwdata_q;
      hrdata_d = hrdata_q;
      cnt_d    = cnt_q;
      to_d     = 1'b0;
      if (accept) begin
         addr_d  = haddr[PADDR_W-1:0];
         write_d = hwrite;
         idx_d   = idx_in;
      end
      case (state_q)
         IDLE, ERR2: state_d = !accept ? IDLE : int'(idx_in) >= NUM_SLV ? ERR1 : hwrite ? WDATA : SETUP;
         WDATA: begin
            pwdata_d = hwdata;
            state_d  = SETUP;
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (rdy) begin
               state_d = err ? ERR1 : IDLE;
               if (!err && !write_q) hrdata_d = rd_slice;
            end else if (tmo) begin
               state_d = ERR1;
               to_d    = 1'b1;
            end else cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
         end
         ERR1: state_d = ERR2;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         write_q  <= 1'b0;
         idx_q    <= '0;
         pwdata_q <= '0;
         hrdata_q <= '0;
         cnt_q    <= '0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         idx_q    <= idx_d;
         pwdata_q <= pwdata_d;
         hrdata_q <= hrdata_d;
         cnt_q    <= cnt_d;
         to_q     <= to_d;
      end
   end
   assign hreadyout = state_q == IDLE || state_q == ERR2;
   assign hresp     = state_q == ERR1 || state_q == ERR2;
   assign hrdata    = hrdata_q;
   assign paddr     = addr_q;
   assign psel      = (state_q == SETUP || state_q == ACCESS) ? sel_oh : '0;
   assign penable   = state_q == ACCESS;
   assign pwrite    = write_q;
   assign pwdata    = pwdata_q;
   assign to_event  = to_q;
endmodule

// File: tb/tb_ahb2apb_bridge_nslv.sv
// tb_ahb2apb_bridge_nslv: randomized transaction-level check of the AHB to APB bridge
module tb_ahb2apb_bridge_nslv;
   localparam int NS  = 12;
   localparam int TMO = 4;
   logic           hclk = 1'b0;
   logic           hreset, hsel, hwrite, hready;
   logic [31:0]    haddr, hwdata;
   logic [1:0]     htrans;
   logic           hreadyout, hresp, penable, pwrite, to_event;
   logic [31:0]    hrdata, paddr, pwdata;
   logic [NS-1:0]  psel, pready, pslverr;
   logic [NS*32-1:0] prdata;
   logic [31:0]    exp_hrdata;
   int             n_vec = 0;
   int             n_err = 0;
   ahb2apb_bridge_nslv #(.NUM_SLV(NS), .TIMEOUT(TMO)) dut (
      .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hready(hready), .hwdata(hwdata), .hreadyout(hreadyout),
      .hresp(hresp), .hrdata(hrdata), .paddr(paddr), .psel(psel), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .to_event(to_event)
   );
   always #5 hclk = ~hclk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   // One AHB transfer plus a reactive APB slave; called at a negedge where hreadyout=1,
   // returns at the negedge of the completion cycle so the next call pipelines into it.
   task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [31:0] rd, input int stall, input logic serr);
      int idx, waits, pen, tos, bad, acc, exp_w;
      logic dec, tmo, ok, last_hresp;
      logic [NS-1:0] por, plast, exp_oh;
      idx = int'(a[15:12]);
      dec = idx >= NS;
      tmo = !dec && stall >= TMO;
      ok  = !dec && !tmo && !serr;
      exp_oh = '0;
      if (!dec) exp_oh[idx] = 1'b1;
      exp_w = dec ? 1 : tmo ? (w ? 1 : 0) + TMO + 2 : (w ? 3 : 2) + stall + (serr ? 1 : 0);
      for (int i = 0; i < NS; i++) prdata[i*32 +: 32] = $urandom;
      if (!dec) prdata[idx*32 +: 32] = rd;
      hsel = 1'b1;
      hready = 1'b1;
      htrans = $urandom_range(0, 1) ? 2'b10 : 2'b11;
      hwrite = w;
      haddr = a;
      hwdata = $urandom;
      pready = NS'($urandom);
      pslverr = NS'($urandom);
      waits = 0; pen = 0; tos = 0; bad = 0; acc = 0;
      por = '0; plast = '0; last_hresp = 1'b0;
      @(negedge hclk);
      while (!hreadyout && waits < 40) begin
         waits++;
         por |= psel;
         plast = psel;
         last_hresp = hresp;
         tos += int'(to_event);
         if (penable) begin
            pen++;
            acc++;
         end
         if (psel != '0 && (paddr != a || pwrite != w || (w && pwdata != wd))) bad++;
         hsel = 1'($urandom);
         htrans = 2'b00;
         hwdata = (w && waits == 1) ? wd : $urandom;
         pready = NS'($urandom);
         pslverr = NS'($urandom);
         if (!dec) begin
            pready[idx] = penable && acc > stall;
            if (pready[idx]) pslverr[idx] = serr;
         end
         @(negedge hclk);
      end
      tos += int'(to_event);
      if (ok && !w) exp_hrdata = rd;
      check("waits", waits, exp_w);
      check("hresp", hresp, !ok);
      check("hrdata", hrdata, exp_hrdata);
      check("psel_seen", 32'(por), 32'(exp_oh));
      check("psel_last", 32'(plast), ok ? 32'(exp_oh) : 32'd0);
      check("err1_hresp", last_hresp, !ok);
      check("penable_cyc", pen, dec ? 0 : tmo ? TMO : stall + 1);
      check("to_event", tos, tmo ? 1 : 0);
      check("apb_stable", bad, 0);
   endtask
   task automatic idle_cycle();
      int v;
      v = $urandom_range(0, 2);
      hsel = v != 0;
      hready = v != 2;
      htrans = v == 1 ? 2'($urandom_range(0, 1)) : 2'b10;
      haddr = $urandom;
      hwrite = 1'($urandom);
      @(negedge hclk);
      check("idle_rdy", hreadyout, 1'b1);
      check("idle_resp", hresp, 1'b0);
      check("idle_psel", 32'(psel), 32'd0);
      check("idle_hrdata", hrdata, exp_hrdata);
      hsel = 1'b0;
      hready = 1'b1;
      htrans = 2'b00;
   endtask
   initial begin
      hreset = 1'b1;
      hsel = 1'b0; hwrite = 1'b0; hready = 1'b1; htrans = 2'b00;
      haddr = '0; hwdata = '0; prdata = '0; pready = '0; pslverr = '0;
      exp_hrdata = '0;
      #7;
      check("rst_rdy", hreadyout, 1'b1);
      check("rst_resp", hresp, 1'b0);
      check("rst_psel", 32'(psel), 32'd0);
      check("rst_pen", penable, 1'b0);
      check("rst_paddr", paddr, 32'd0);
      check("rst_hrdata", hrdata, 32'd0);
      check("rst_to", to_event, 1'b0);
      @(negedge hclk);
      hreset = 1'b0;
      xfer(32'h0000_3010, 1'b0, 32'h0, 32'hA5A5_1234, 0, 1'b0);
      xfer(32'h0000_B004, 1'b1, 32'hDEAD_BEEF, 32'h0, 3, 1'b0);
      xfer(32'h0000_C000, 1'b1, $urandom, 32'h0, 0, 1'b0);
      xfer(32'h0000_5020, 1'b0, 32'h0, 32'h1111_2222, 0, 1'b1);
      xfer(32'h0000_0000, 1'b0, 32'h0, 32'h3333_0000, 4, 1'b0);
      xfer(32'h0000_0004, 1'b0, 32'h0, 32'h4444_0000, 3, 1'b0);
      idle_cycle();
      repeat (200) begin
         if ($urandom_range(0, 3) == 0) idle_cycle();
         xfer({16'h0, 4'($urandom_range(0, 15)), 12'($urandom)}, 1'($urandom), $urandom,
              $urandom, $urandom_range(0, 5), $urandom_range(0, 3) == 0);
      end
      xfer(32'h0000_7000, 1'b0, 32'h0, 32'h9ABC_DEF0, 0, 1'b0);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0000_B008;
      pready = '0; pslverr = '0;
      @(negedge hclk);
      htrans = 2'b00; hwdata = 32'h1234_5678;
      @(negedge hclk);
      @(negedge hclk);
      check("rst_pre_pen", penable, 1'b1);
      #2 hreset = 1'b1;
      #1;
      check("mrst_rdy", hreadyout, 1'b1);
      check("mrst_resp", hresp, 1'b0);
      check("mrst_psel", 32'(psel), 32'd0);
      check("mrst_pen", penable, 1'b0);
      check("mrst_paddr", paddr, 32'd0);
      check("mrst_pwrite", pwrite, 1'b0);
      check("mrst_pwdata", pwdata, 32'd0);
      check("mrst_hrdata", hrdata, 32'd0);
      check("mrst_to", to_event, 1'b0);
      exp_hrdata = '0;
      @(negedge hclk);
      hreset = 1'b0;
      hsel = 1'b0;
      xfer(32'h0000_1000, 1'b0, 32'h0, $urandom, 0, 1'b0);
      xfer(32'h0000_2000, 1'b0, 32'h0, $urandom, 0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ahb2apb_bridge_nslv.md
Name: ahb2apb_bridge_nslv

Overview:
Parametrised AHB-Lite slave to APB master bridge that drives NUM_SLV APB completers with one-hot psel decoded from the address. It supports APB wait states (pready), slave error (pslverr) and an APB access timeout, and returns a two-cycle AHB ERROR response for each of them. It replaces the fixed 12-slave bridge top and sits between the AHB interconnect and the peripheral APB bus.

Parameters:
HADDR_W, 32, AHB address width
PADDR_W, 32, APB address width (paddr = registered haddr[PADDR_W-1:0])
DATA_W, 32, AHB and APB data width
NUM_SLV, 12, number of APB slaves (1..16)
SEL_LSB, 12, lowest address bit of the slave index field (4 KB per slave)
SEL_W, 4, width of the slave index field haddr[SEL_LSB +: SEL_W]; 2^SEL_W >= NUM_SLV
TIMEOUT, 256, max consecutive ACCESS cycles with pready low; 0 disables the timeout

Ports:
hclk  in  1  system clock
hreset  in  1  asynchronous reset, active-high
hsel  in  1  AHB slave select
haddr  in  HADDR_W  AHB address
htrans  in  2  AHB transfer type
hwrite  in  1  1 = write
hready  in  1  AHB bus ready (sampled with the address phase)
hwdata  in  DATA_W  AHB write data
hreadyout  out  1  bridge ready
hresp  out  1  0 = OKAY, 1 = ERROR
hrdata  out  DATA_W  read data
paddr  out  PADDR_W  APB address
psel  out  NUM_SLV  one-hot APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
prdata  in  NUM_SLV*DATA_W  flattened read data; slave i occupies bits [i*DATA_W +: DATA_W]
pready  in  NUM_SLV  per-slave ready
pslverr  in  NUM_SLV  per-slave error
to_event  out  1  one-cycle pulse when an APB timeout occurs

Behaviour:
- Reset: asynchronous, active-high, effective at any time including mid-transfer.
  - FSM goes to IDLE; psel=0, penable=0.
  - paddr, pwrite, pwdata and hrdata go to 0.
  - hreadyout=1, hresp=0, to_event=0.
- Transfer accept: a transfer is accepted when hsel & hready & htrans[1] (NONSEQ or SEQ), in state IDLE or ERR2.
  - On accept: register haddr, hwrite and the slave index idx.
- No-transfer cases: IDLE/BUSY htrans, or hsel low, give a zero-wait OKAY response and start no APB cycle.
- Decode: idx >= NUM_SLV is a decode error.
  - Next state is ERR1; no psel is asserted and hwdata is ignored.
- FSM states: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
  - IDLE: hreadyout=1, hresp=0. On accept go to ERR1 (decode error), WDATA (write) or SETUP (read).
  - WDATA: hreadyout=0. Capture hwdata into pwdata, then go to SETUP.
  - SETUP: psel[idx]=1, penable=0, hreadyout=0. Go to ACCESS.
  - ACCESS: psel[idx]=1, penable=1, hreadyout=0. Exits:
    - pready[idx]=1 & pslverr[idx]=0: latch prdata slice into hrdata (reads only; hrdata holds on writes), go to IDLE. The following cycle shows hreadyout=1, hresp=0.
    - pready[idx]=1 & pslverr[idx]=1: go to ERR1.
    - pready[idx]=0 for TIMEOUT consecutive ACCESS cycles (TIMEOUT != 0): go to ERR1 and pulse to_event for one cycle.
  - ERR1: hresp=1, hreadyout=0, psel=0, penable=0. Go to ERR2.
  - ERR2: hresp=1, hreadyout=1. Accept rule as in IDLE; with no accept, go to IDLE.
- APB signal stability: paddr, pwrite and pwdata are stable from SETUP through the end of ACCESS. psel and penable drop in the cycle after ACCESS completes.
- Back-to-back transfers: no extra idle cycle. The next address is accepted in the completion cycle (IDLE with hreadyout=1).
- Latency with zero APB wait states:
  - Read: 2 AHB wait states; hrdata valid in cycle T3 after the address phase at T0.
  - Write: 3 AHB wait states.
  - Each cycle of pready low adds one wait state.
- Timeout counter:
  - Width is clog2(TIMEOUT+1).
  - Clears on entry to ACCESS.
  - Increments each ACCESS cycle with pready low; never wraps.
- Simultaneous events: if pready and pslverr are both high in the cycle the timeout would fire, pready takes precedence. The transfer completes per pslverr and no timeout is flagged.
- pslverr is sampled only when pready[idx]=1. pready and pslverr of unselected slaves are ignored.

Test Plan:
- Read slave 3 at addr 0x0000_3010, pready_3=1, prdata slice 3 = 0xA5A5_1234 → psel=0x008, paddr=0x3010; hreadyout low for 2 cycles; hrdata=0xA5A5_1234 with hresp=0.
- Write 0xDEAD_BEEF to 0x0000_B004 with pready_11 low for 3 ACCESS cycles → pwdata=0xDEAD_BEEF stable from SETUP to completion; penable high 4 cycles; hreadyout low for 6 cycles total; OKAY.
- Access 0x0000_C000 (idx 12, NUM_SLV=12) → psel stays 0; ERR1 shows hresp=1/hreadyout=0, ERR2 shows hresp=1/hreadyout=1.
- Slave 5 returns pready=1 with pslverr=1 on a read → two-cycle ERROR response; hrdata unchanged.
- TIMEOUT=4, slave 0 holds pready=0 → ERR1 after exactly 4 ACCESS cycles, to_event pulses once, psel=0 in ERR1. Repeat with pready rising in the 4th cycle → OKAY, no to_event.
- Assert hreset during ACCESS of a write, then issue back-to-back reads to slaves 1 and 2 → outputs take reset values immediately. After release, the second address is accepted in the first read's completion cycle with no idle cycle on APB.
